// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and constants for the shift-register command sequencer.
// Holds the opcode/state encodings and the shift-amount clamp helper.
package shift_seq_pkg;

    localparam int SEQ_WIDTH = 4;
    localparam int SEQ_AMT_W = 4;
    localparam int MAX_STEP  = 3;

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_LOAD = 2'b01,
        OP_SHR  = 2'b10,
        OP_SHL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_SETTLE,
        ST_RSP
    } state_e;

    // Shifting by the full width or more always empties the register.
    function automatic int sat_amt(input int amt, input int width);
        return (amt > width) ? width : amt;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command and response channels between the bus-side source and the sequencer.
// master = command source / response consumer, slave = sequencer.
interface shift_seq_ctrl_if
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int AMT_W = SEQ_AMT_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [AMT_W-1:0] cmd_amt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_amt, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_amt, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/shift_seq_ctrl_shift_step_calc.sv
// Splits a remaining shift amount into one register step (at most MAX_STEP)
// and the amount still outstanding after that step.
module shift_step_calc
    import shift_seq_pkg::*;
#(
    parameter int REM_W = 3
) (
    input  logic [REM_W-1:0] i_rem,
    output logic [1:0]       o_step,
    output logic [REM_W-1:0] o_rem_next
);

    logic [1:0] w_step;

    assign w_step     = (i_rem > REM_W'(MAX_STEP)) ? 2'(MAX_STEP) : i_rem[1:0];
    assign o_step     = w_step;
    assign o_rem_next = i_rem - REM_W'(w_step);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving a 4-bit barrel-step shift register: one command
// in, the required load/shift steps out, then the register contents returned.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int AMT_W = SEQ_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] sr_din,
    output logic             sr_ld,
    output logic             sr_sr,
    output logic             sr_sl,
    output logic [1:0]       sr_cnt,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy
);

    localparam int REM_W = $clog2(WIDTH + 1);

    state_e           r_state, w_state_next;
    op_e              r_op, w_op_next;
    logic [REM_W-1:0] r_rem, w_rem_next;
    logic [WIDTH-1:0] r_sr_din, w_sr_din_next;
    logic             r_sr_ld, w_sr_ld_next;
    logic             r_sr_sr, w_sr_sr_next;
    logic             r_sr_sl, w_sr_sl_next;
    logic [1:0]       r_sr_cnt, w_sr_cnt_next;
    logic [WIDTH-1:0] r_rsp_data, w_rsp_data_next;
    logic             r_rsp_valid, r_cmd_ready, r_busy;

    logic             w_accept;
    logic [REM_W-1:0] w_rem_src, w_step_rem;
    logic [1:0]       w_step;

    assign w_accept = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;

    // First step is issued on the accept edge, so the calculator sees the
    // fresh command amount in IDLE and the stored remainder afterwards.
    assign w_rem_src = (r_state == ST_IDLE) ?
                       REM_W'(sat_amt(int'(bus.cmd_amt), WIDTH)) : r_rem;

    shift_step_calc #(.REM_W(REM_W)) u_step_calc (
        .i_rem      (w_rem_src),
        .o_step     (w_step),
        .o_rem_next (w_step_rem)
    );

    always_comb begin
        w_state_next    = r_state;
        w_op_next       = r_op;
        w_rem_next      = r_rem;
        w_sr_din_next   = r_sr_din;
        w_sr_ld_next    = 1'b0;
        w_sr_sr_next    = 1'b0;
        w_sr_sl_next    = 1'b0;
        w_sr_cnt_next   = 2'd0;
        w_rsp_data_next = r_rsp_data;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_op_next = bus.cmd_op;
                    case (bus.cmd_op)
                        OP_LOAD: begin
                            w_state_next  = ST_LOAD;
                            w_sr_ld_next  = 1'b1;
                            w_sr_din_next = bus.cmd_data;
                        end
                        OP_SHR, OP_SHL: begin
                            if (w_rem_src != '0) begin
                                w_state_next  = ST_SHIFT;
                                w_sr_sr_next  = (bus.cmd_op == OP_SHR);
                                w_sr_sl_next  = (bus.cmd_op == OP_SHL);
                                w_sr_cnt_next = w_step;
                                w_rem_next    = w_step_rem;
                            end else begin
                                w_state_next = ST_SETTLE;
                            end
                        end
                        default: w_state_next = ST_SETTLE;
                    endcase
                end
            end
            ST_LOAD: w_state_next = ST_SETTLE;
            ST_SHIFT: begin
                if (r_rem != '0) begin
                    w_sr_sr_next  = (r_op == OP_SHR);
                    w_sr_sl_next  = (r_op == OP_SHL);
                    w_sr_cnt_next = w_step;
                    w_rem_next    = w_step_rem;
                end else begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_rsp_data_next = sr_q;
                w_state_next    = ST_RSP;
            end
            ST_RSP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_READ;
            r_rem       <= '0;
            r_sr_din    <= '0;
            r_sr_ld     <= 1'b0;
            r_sr_sr     <= 1'b0;
            r_sr_sl     <= 1'b0;
            r_sr_cnt    <= 2'd0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_op        <= w_op_next;
            r_rem       <= w_rem_next;
            r_sr_din    <= w_sr_din_next;
            r_sr_ld     <= w_sr_ld_next;
            r_sr_sr     <= w_sr_sr_next;
            r_sr_sl     <= w_sr_sl_next;
            r_sr_cnt    <= w_sr_cnt_next;
            r_rsp_data  <= w_rsp_data_next;
            r_rsp_valid <= (w_state_next == ST_RSP);
            r_cmd_ready <= (w_state_next == ST_IDLE);
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    assign sr_din        = r_sr_din;
    assign sr_ld         = r_sr_ld;
    assign sr_sr         = r_sr_sr;
    assign sr_sl         = r_sr_sl;
    assign sr_cnt        = r_sr_cnt;
    assign busy          = r_busy;
    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural model of the
// barrel-step shift register closing the loop on sr_q.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] sr_din;
    logic       sr_ld, sr_sr, sr_sl;
    logic [1:0] sr_cnt;
    logic [3:0] sr_q;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    shift_seq_ctrl_if bus ();

    shift_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .sr_din (sr_din),
        .sr_ld  (sr_ld),
        .sr_sr  (sr_sr),
        .sr_sl  (sr_sl),
        .sr_cnt (sr_cnt),
        .sr_q   (sr_q),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift register being sequenced: load, or logical shift by s_cnt.
    initial sr_q = 4'd0;
    always @(posedge clk) begin
        if (sr_ld)      sr_q <= sr_din;
        else if (sr_sr) sr_q <= sr_q >> sr_cnt;
        else if (sr_sl) sr_q <= sr_q << sr_cnt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at accept edge + 1; follows the command to its response and handshake.
    task automatic collect(input string tag, input logic [3:0] exp_data, input int exp_lat,
                           input int exp_ld, input int exp_shr, input int exp_shl,
                           input logic [7:0] exp_seq, input logic [3:0] exp_din);
        int         lat;
        int         n_ld, n_shr, n_shl, n_multi;
        logic [7:0] seq;
        logic [3:0] din_seen;
        lat = 1; n_ld = 0; n_shr = 0; n_shl = 0; n_multi = 0;
        seq = 8'd0; din_seen = 4'd0;
        while (!bus.rsp_valid && lat < 20) begin
            if (sr_ld) begin n_ld++; din_seen = sr_din; end
            if (sr_sr) n_shr++;
            if (sr_sl) n_shl++;
            if (sr_sr || sr_sl) seq = {seq[5:0], sr_cnt};
            if (int'(sr_ld) + int'(sr_sr) + int'(sr_sl) > 1) n_multi++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
        check({tag, ":ld_cycles"}, 32'(n_ld), 32'(exp_ld));
        check({tag, ":shr_cycles"}, 32'(n_shr), 32'(exp_shr));
        check({tag, ":shl_cycles"}, 32'(n_shl), 32'(exp_shl));
        check({tag, ":cnt_seq"}, 32'(seq), 32'(exp_seq));
        check({tag, ":exclusive"}, 32'(n_multi), 32'd0);
        if (exp_ld != 0) check({tag, ":sr_din"}, 32'(din_seen), 32'(exp_din));
        check({tag, ":ctrl_idle_in_rsp"}, 32'({sr_ld, sr_sr, sr_sl, sr_cnt}), 32'd0);
        $display("[TB] %s data=%b latency=%0d ld=%0d shr=%0d shl=%0d cnt_seq=%h",
                 tag, bus.rsp_data, lat, n_ld, n_shr, n_shl, seq);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, ":rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ":cmd_ready_back"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, ":busy_clear"}, 32'(busy), 32'd0);
    endtask

    task automatic issue(input op_e op, input logic [3:0] data, input logic [3:0] amt);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_amt   = amt;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input op_e op, input logic [3:0] data,
                           input logic [3:0] amt, input logic [3:0] exp_data, input int exp_lat,
                           input int exp_ld, input int exp_shr, input int exp_shl,
                           input logic [7:0] exp_seq);
        issue(op, data, amt);
        collect(tag, exp_data, exp_lat, exp_ld, exp_shr, exp_shl, exp_seq, data);
    endtask

    initial begin
        int n_rsp;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_READ;
        bus.cmd_data  = 4'd0;
        bus.cmd_amt   = 4'd0;
        bus.rsp_ready = 1'b0;

        #1;
        check("reset:outputs", 32'({sr_ld, sr_sr, sr_sl, sr_cnt, sr_din}), 32'd0);
        check("reset:handshake", 32'({bus.cmd_ready, bus.rsp_valid, busy, bus.rsp_data}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("post_reset:cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("post_reset:busy", 32'(busy), 32'd0);

        run_cmd("load_1011", OP_LOAD, 4'b1011, 4'd0, 4'b1011, 3, 1, 0, 0, 8'h00);
        run_cmd("shr_2",     OP_SHR,  4'b0000, 4'd2, 4'b0010, 3, 0, 1, 0, 8'h02);
        run_cmd("load_1111", OP_LOAD, 4'b1111, 4'd0, 4'b1111, 3, 1, 0, 0, 8'h00);
        run_cmd("shl_5",     OP_SHL,  4'b0000, 4'd5, 4'b0000, 4, 0, 0, 2, 8'h0D);
        run_cmd("load_0110", OP_LOAD, 4'b0110, 4'd0, 4'b0110, 3, 1, 0, 0, 8'h00);
        run_cmd("shr_0",     OP_SHR,  4'b0000, 4'd0, 4'b0110, 2, 0, 0, 0, 8'h00);
        run_cmd("read",      OP_READ, 4'b0000, 4'd0, 4'b0110, 2, 0, 0, 0, 8'h00);

        // Back-pressure: response held while a new command waits on cmd_valid.
        issue(OP_READ, 4'd0, 4'd0);
        @(posedge clk); #1;
        check("hold:rsp_valid_up", 32'(bus.rsp_valid), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_data  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold:rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold:rsp_data", 32'(bus.rsp_data), 32'b0110);
            check("hold:cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("hold:ctrl", 32'({sr_ld, sr_sr, sr_sl, sr_cnt}), 32'd0);
        end
        $display("[TB] hold rsp_data=%b held 5 cycles", bus.rsp_data);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("hold:handshake_drop", 32'(bus.rsp_valid), 32'd0);
        check("hold:no_early_accept", 32'(sr_ld), 32'd0);
        check("hold:cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        collect("held_load_0001", 4'b0001, 3, 1, 0, 0, 8'h00, 4'b0001);

        // Reset during the first step of a saturating left shift.
        issue(OP_SHL, 4'd0, 4'd9);
        check("abort:first_step_sl", 32'(sr_sl), 32'd1);
        check("abort:first_step_cnt", 32'(sr_cnt), 32'd3);
        #2 rst = 1'b0;
        #1;
        check("abort:ctrl_zero", 32'({sr_ld, sr_sr, sr_sl, sr_cnt, sr_din}), 32'd0);
        check("abort:hs_zero", 32'({bus.cmd_ready, bus.rsp_valid, busy, bus.rsp_data}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort:busy_after", 32'(busy), 32'd0);
        check("abort:cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
        n_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid) n_rsp++;
            @(posedge clk); #1;
        end
        check("abort:no_response", 32'(n_rsp), 32'd0);
        $display("[TB] abort shl_9 responses_after_reset=%0d", n_rsp);

        run_cmd("recover_load_1010", OP_LOAD, 4'b1010, 4'd0, 4'b1010, 3, 1, 0, 0, 8'h00);
        run_cmd("recover_shr_3",     OP_SHR,  4'b0000, 4'd3, 4'b0001, 3, 0, 1, 0, 8'h03);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
